// File: rtl/dibit_packet_rx_if.sv
// rtl/dibit_packet_rx_if.sv - link dibit input and frame-buffer write port bundle
interface dibit_packet_rx_if #(
  parameter int ADDR_WIDTH = 17
);
  logic                  axiiv;
  logic [1:0]            axiid;
  logic                  pixel_wr_en;
  logic [ADDR_WIDTH-1:0] pixel_wr_addr;
  logic [7:0]            pixel_wr_data;
  logic                  packet_done;
  logic                  packet_err;

  modport master (
    output axiiv, axiid,
    input  pixel_wr_en, pixel_wr_addr, pixel_wr_data, packet_done, packet_err
  );

  modport slave (
    input  axiiv, axiid,
    output pixel_wr_en, pixel_wr_addr, pixel_wr_data, packet_done, packet_err
  );
endinterface

// File: rtl/dibit_packet_rx.sv
// rtl/dibit_packet_rx.sv - dibit link receiver: header/pixel reassembly into frame-buffer writes
module dibit_packet_rx #(
  parameter int PIXELS_PER_PACKET = 320,
  parameter int ADDR_WIDTH        = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  dibit_packet_rx_if.slave link
);

  localparam int PCW = (PIXELS_PER_PACKET > 1) ? $clog2(PIXELS_PER_PACKET) : 1;
  localparam logic [PCW-1:0] PIX_LAST = PCW'(PIXELS_PER_PACKET - 1);

  typedef enum logic [1:0] {IDLE, HDR, PIX, DRAIN} state_t;

  state_t                state, state_next;
  logic [1:0]            dibit_cnt;
  logic [3:0]            hdr_cnt;
  logic [PCW-1:0]        pix_cnt;
  logic [5:0]            byte_sr;
  logic [ADDR_WIDTH-1:0] hdr_sr;
  logic [ADDR_WIDTH-1:0] wr_ptr;

  logic                  take;
  logic                  in_hdr;
  logic                  abort;
  logic                  byte_done;
  logic                  hdr_last;
  logic                  pix_last;
  logic [7:0]            byte_val;
  logic [ADDR_WIDTH-1:0] hdr_next;

  // Current dibit completes the byte on top of the three already shifted in;
  // header bytes arrive MSB first so each new byte shifts the header left by 8,
  // and bits above ADDR_WIDTH fall off the top.
  assign byte_val = {link.axiid, byte_sr};
  assign hdr_next = ADDR_WIDTH'({hdr_sr, byte_val});

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and per-cycle control decode
  always_comb begin
    state_next = state;
    take       = 1'b0;
    in_hdr     = 1'b0;
    abort      = 1'b0;
    byte_done  = 1'b0;
    hdr_last   = 1'b0;
    pix_last   = 1'b0;
    case (state)
      IDLE: begin
        if (link.axiiv) begin
          take       = 1'b1;
          in_hdr     = 1'b1;
          state_next = HDR;
        end
      end
      HDR: begin
        if (link.axiiv) begin
          take   = 1'b1;
          in_hdr = 1'b1;
          if (hdr_cnt == 4'd11) begin
            hdr_last   = 1'b1;
            state_next = PIX;
          end
        end else begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      PIX: begin
        if (link.axiiv) begin
          take = 1'b1;
          if (dibit_cnt == 2'd3) begin
            byte_done = 1'b1;
            if (pix_cnt == PIX_LAST) begin
              pix_last   = 1'b1;
              state_next = DRAIN;
            end
          end
        end else begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      DRAIN: begin
        if (!link.axiiv) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Dibit/header/pixel counters, byte assembly and write pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dibit_cnt <= 2'd0;
      hdr_cnt   <= 4'd0;
      pix_cnt   <= '0;
      byte_sr   <= 6'd0;
      hdr_sr    <= '0;
      wr_ptr    <= '0;
    end else if (abort) begin
      dibit_cnt <= 2'd0;
      hdr_cnt   <= 4'd0;
      pix_cnt   <= '0;
    end else if (take) begin
      dibit_cnt <= dibit_cnt + 2'd1;
      byte_sr   <= {link.axiid, byte_sr[5:2]};
      if (in_hdr) begin
        hdr_cnt <= hdr_last ? 4'd0 : hdr_cnt + 4'd1;
        if (dibit_cnt == 2'd3) hdr_sr <= hdr_next;
        if (hdr_last) begin
          wr_ptr  <= hdr_next;
          pix_cnt <= '0;
        end
      end else if (byte_done) begin
        pix_cnt <= pix_last ? '0 : pix_cnt + PCW'(1);
        wr_ptr  <= wr_ptr + 1'b1;
      end
    end
  end

  // Registered write port and status pulses; address/data hold between writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link.pixel_wr_en   <= 1'b0;
      link.pixel_wr_addr <= '0;
      link.pixel_wr_data <= 8'd0;
      link.packet_done   <= 1'b0;
      link.packet_err    <= 1'b0;
    end else begin
      link.pixel_wr_en <= byte_done;
      link.packet_done <= pix_last;
      link.packet_err  <= abort;
      if (byte_done) begin
        link.pixel_wr_addr <= wr_ptr;
        link.pixel_wr_data <= byte_val;
      end
    end
  end

endmodule
